// File: rtl/tube_pkg.sv
// Shared types and constants for the Tube register-3 DMA sequencer.
// No logic of its own; imported by the sequencer top.
// No flow control.
package tube_pkg;

    // Transfer direction as sampled with start
    localparam logic DIR_H2P = 1'b0;  // drain HP3 (host to parasite)
    localparam logic DIR_P2H = 1'b1;  // fill PH3 (parasite to host)

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_ACK,
        ST_SETTLE,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/tube_sync.sv
// Two-flop synchroniser for an asynchronous level flag.
// Latency: 2 clk cycles from flag change to q_o.
// No flow control; the output simply follows the input level.
module tube_sync (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tube_dma_ctrl.sv
// Parasite-side DMA sequencer for Tube register 3: drq generation, beat pacing, byte count, timeout.
// Latency: FIFO flag to drq 4 cycles; final dack_b release to done 1 cycle; all outputs registered.
// Backpressure: each beat waits for dack_b low then high; drq waits at most TMO_CYC cycles before ERR.
module tube_dma_ctrl
    import tube_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 3,
    parameter int TMO_CYC    = 255
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             tube_reset,
    input  logic             start,
    input  logic             dir,
    input  logic             two_byte,
    input  logic [CNT_W-1:0] count,
    input  logic             hp3_full_a,
    input  logic             ph3_full_a,
    input  logic             dack_b,
    output logic             drq,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [7:0] TMO_LIM   = 8'(TMO_CYC);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             two_q, two_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       beat_q, beat_d;
    logic [3:0]       settle_q, settle_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             drq_q, drq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic hp3_full_s;
    logic ph3_full_s;
    logic fifo_rdy;

    tube_sync u_sync_hp3 (
        .clk_i   (clk),
        .rst_b_i (rst_b),
        .d_i     (hp3_full_a),
        .q_o     (hp3_full_s)
    );

    tube_sync u_sync_ph3 (
        .clk_i   (clk),
        .rst_b_i (rst_b),
        .d_i     (ph3_full_a),
        .q_o     (ph3_full_s)
    );

    // H2P needs a byte waiting in HP3; P2H needs PH3 to have room
    assign fifo_rdy = (dir_q == DIR_P2H) ? !ph3_full_s : hp3_full_s;

    // Next-state and registered-output decode; outputs reflect the state just left
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        two_d    = two_q;
        rem_d    = rem_q;
        beat_d   = beat_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        drq_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        if (tube_reset && (state_q != ST_IDLE)) begin
            // Abort: drop the request, keep the residual count and error flag
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !tube_reset) begin
                        dir_d    = dir;
                        two_d    = two_byte;
                        rem_d    = count;
                        err_d    = 1'b0;
                        busy_d   = 1'b1;
                        settle_d = 4'd0;
                        state_d  = (count == '0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fifo_rdy && (settle_q == 4'd0)) begin
                        beat_d  = two_q ? 2'd2 : 2'd1;
                        tmo_d   = 8'd0;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    drq_d = 1'b1;
                    if (!dack_b) begin
                        state_d = ST_ACK;
                    end else if ((tmo_q + 8'd1) == TMO_LIM) begin
                        state_d = ST_ERR;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                ST_ACK: begin
                    if (dack_b) begin
                        rem_d  = (rem_q != '0) ? rem_q - CNT_W'(1) : '0;
                        beat_d = (beat_q != 2'd0) ? beat_q - 2'd1 : 2'd0;
                        if (rem_q <= CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else if (beat_q > 2'd1) begin
                            // Second byte of a pair goes straight out without a flag check
                            tmo_d   = 8'd0;
                            state_d = ST_REQ;
                        end else begin
                            // Flags are stale until the synchronisers catch up
                            settle_d = SETTLE_LD;
                            state_d  = ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_q <= 4'd1) begin
                        settle_d = 4'd0;
                        state_d  = ST_WAIT;
                    end else begin
                        settle_d = settle_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_ERR: begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_H2P;
            two_q    <= 1'b0;
            rem_q    <= '0;
            beat_q   <= 2'd0;
            settle_q <= 4'd0;
            tmo_q    <= 8'd0;
            drq_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            two_q    <= two_d;
            rem_q    <= rem_d;
            beat_q   <= beat_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            drq_q    <= drq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign drq       = drq_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_tube_dma_ctrl.sv
// Directed self-checking bench for tube_dma_ctrl.
// Inputs driven 1 ns after the rising edge; outputs sampled at the same point.
// A small DMA-acknowledge model drives dack_b low for two cycles per beat.
module tb_tube_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        tube_reset = 1'b0;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        two_byte = 1'b0;
    logic [15:0] count = 16'd0;
    logic        hp3_full_a = 1'b0;
    logic        ph3_full_a = 1'b0;
    logic        dack_b = 1'b1;
    logic        drq;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] remaining;

    int n_cmp = 0;
    int n_bad = 0;
    int drq_rises = 0;
    int done_cnt = 0;
    logic drq_prev = 1'b0;

    tube_dma_ctrl dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .tube_reset (tube_reset),
        .start      (start),
        .dir        (dir),
        .two_byte   (two_byte),
        .count      (count),
        .hp3_full_a (hp3_full_a),
        .ph3_full_a (ph3_full_a),
        .dack_b     (dack_b),
        .drq        (drq),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    // Count drq pulses and done pulses on the falling edge
    always @(negedge clk) begin
        drq_prev <= drq;
        if (drq && !drq_prev) drq_rises <= drq_rises + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until drq is seen high; lat is the number of steps taken, 99 if never
    task automatic wait_drq(output int lat);
        int i;
        i = 0;
        lat = 99;
        while (i < 60) begin
            step();
            i++;
            if (drq === 1'b1) begin
                lat = i;
                i = 60;
            end
        end
    endtask

    // One beat: dack_b low for two cycles, then released; returns one step after release is seen
    task automatic dma_beat(input bit tog_hp3);
        dack_b = 1'b0;
        if (tog_hp3) hp3_full_a = 1'b0;
        step();
        step();
        dack_b = 1'b1;
        if (tog_hp3) hp3_full_a = 1'b1;
        step();
    endtask

    task automatic pulse_start(input logic d, input logic tb, input logic [15:0] c);
        start = 1'b1;
        dir = d;
        two_byte = tb;
        count = c;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int r0;
        int d0;
        int hi;
        int exp_lat[4];
        exp_lat[0] = 1; exp_lat[1] = 5; exp_lat[2] = 1; exp_lat[3] = 5;

        // Reset values
        #12;
        chk("rst_drq", drq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_remaining", remaining, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        step();

        // count = 0: done two cycles after start, no drq
        r0 = drq_rises;
        pulse_start(1'b0, 1'b0, 16'd0);
        chk("zero_busy", busy, 1);
        chk("zero_done_early", done, 0);
        step();
        chk("zero_done", done, 1);
        chk("zero_busy_clr", busy, 0);
        step();
        chk("zero_no_drq", drq_rises - r0, 0);

        // H2P, 3 single-byte beats, HP3 flag toggled per byte
        r0 = drq_rises;
        d0 = done_cnt;
        pulse_start(1'b0, 1'b0, 16'd3);
        chk("h2p_start_rem", remaining, 3);
        hp3_full_a = 1'b1;
        wait_drq(lat);
        chk("h2p_flag_lat", lat, 4);
        dma_beat(1'b1);
        chk("h2p_rem1", remaining, 2);
        wait_drq(lat);
        chk("h2p_drq2", drq, 1);
        dma_beat(1'b1);
        chk("h2p_rem2", remaining, 1);
        wait_drq(lat);
        chk("h2p_drq3", drq, 1);
        dma_beat(1'b1);
        chk("h2p_rem3", remaining, 0);
        hp3_full_a = 1'b0;
        step();
        step();
        chk("h2p_pulses", drq_rises - r0, 3);
        chk("h2p_done_once", done_cnt - d0, 1);
        chk("h2p_busy_end", busy, 0);

        // P2H, 5 bytes in two-byte mode: pairs 2+2+1 with settle gaps
        pulse_start(1'b1, 1'b1, 16'd5);
        wait_drq(lat);
        chk("p2h_lat0", lat, 2);
        dma_beat(1'b0);
        chk("p2h_rem1", remaining, 4);
        for (int b = 0; b < 4; b++) begin
            wait_drq(lat);
            chk($sformatf("p2h_lat%0d", b + 1), lat, exp_lat[b]);
            dma_beat(1'b0);
            chk($sformatf("p2h_rem%0d", b + 2), remaining, 3 - b);
        end
        chk("p2h_done_early", done, 0);
        step();
        chk("p2h_done", done, 1);

        // Timeout: dack_b never asserted
        step();
        pulse_start(1'b1, 1'b0, 16'd7);
        wait_drq(lat);
        hi = 0;
        if (drq === 1'b1) hi = 1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (drq === 1'b1) hi++;
            else break;
        end
        chk("tmo_drq_cycles", hi, 255);
        chk("tmo_error", error, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_remaining", remaining, 7);
        step();
        pulse_start(1'b0, 1'b0, 16'd0);
        chk("tmo_err_cleared", error, 0);
        step();
        step();

        // start while busy is ignored (PH3 full so it parks in WAIT)
        ph3_full_a = 1'b1;
        repeat (3) step();
        pulse_start(1'b1, 1'b0, 16'd2);
        chk("busy_rem", remaining, 2);
        step();
        pulse_start(1'b0, 1'b0, 16'd9);
        chk("ignored_rem", remaining, 2);
        chk("ignored_busy", busy, 1);
        tube_reset = 1'b1;
        step();
        tube_reset = 1'b0;
        chk("abort_wait_busy", busy, 0);
        ph3_full_a = 1'b0;
        step();

        // tube_reset in REQ of the second beat of four
        d0 = done_cnt;
        pulse_start(1'b0, 1'b0, 16'd4);
        hp3_full_a = 1'b1;
        wait_drq(lat);
        dma_beat(1'b1);
        chk("trst_rem_beat1", remaining, 3);
        wait_drq(lat);
        chk("trst_in_req", drq, 1);
        tube_reset = 1'b1;
        step();
        tube_reset = 1'b0;
        hp3_full_a = 1'b0;
        chk("trst_drq", drq, 0);
        chk("trst_busy", busy, 0);
        chk("trst_rem", remaining, 3);
        repeat (3) step();
        chk("trst_no_done", done_cnt - d0, 0);
        chk("trst_error", error, 0);

        // Asynchronous reset in ACK
        pulse_start(1'b1, 1'b0, 16'd2);
        wait_drq(lat);
        dack_b = 1'b0;
        step();
        #1;
        rst_b = 1'b0;
        #1;
        chk("arst_drq", drq, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_error", error, 0);
        chk("arst_remaining", remaining, 0);
        dack_b = 1'b1;
        step();
        rst_b = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tube_dma_ctrl.md
# tube_dma_ctrl

Parasite-side DMA sequencer for Tube register 3: it generates `drq` from the register-3 FIFO flags, paces each beat on `dack_b`, counts bytes and reports completion or timeout. It sits between the Tube register file (status flags in the host/parasite domains) and the parasite DMA controller, and replaces the tied-off `drq`. Supports single-byte and two-byte (V flag) register-3 modes in both directions.

## Interface
- `CNT_W`, 16: width of byte count.
- `SETTLE_CYC`, 3: cycles after a beat during which FIFO flags are ignored (covers sync latency); legal 2..15.
- `TMO_CYC`, 255: max cycles `drq` may wait for `dack_b`; legal 1..255.

- `clk` in 1: parasite clock; all state on rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `tube_reset` in 1: T flag or host reset, already in `clk` domain; synchronous abort.
- `start` in 1: one-cycle pulse, accepted only in IDLE.
- `dir` in 1: 0 = host→parasite (drain HP3), 1 = parasite→host (fill PH3); sampled with `start`.
- `two_byte` in 1: V flag; sampled with `start`.
- `count` in CNT_W: bytes to move; sampled with `start`; 0 means done immediately.
- `hp3_full_a` in 1: HP3 holds data (async; synchronised internally).
- `ph3_full_a` in 1: PH3 holds data (async; synchronised internally).
- `dack_b` in 1: DMA acknowledge, active low, synchronous to `clk`.
- `drq` out 1: DMA request, registered.
- `busy` out 1: high from accepted `start` until DONE/ERR exits.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky timeout flag; cleared by next accepted `start`.
- `remaining` out CNT_W: bytes still to transfer.

## Operation
- FIFO ready: `dir`=0 → synced `hp3_full`=1; `dir`=1 → synced `ph3_full`=0.
- States: IDLE, WAIT, REQ, ACK, SETTLE, DONE, ERR.
- IDLE: on `start`, latch `dir`/`two_byte`, `remaining`←`count`, clear `error`, go to WAIT (`count`≠0) or DONE (`count`=0).
- WAIT: when FIFO ready and settle counter is 0, go to REQ; load beat budget (2 if `two_byte`, else 1).
- REQ: `drq`=1; timeout counter increments; `dack_b`=0 → ACK; counter reaches `TMO_CYC` → ERR.
- ACK: `drq`=0; on `dack_b`=1, decrement `remaining` and beat budget. `remaining`=0 → DONE; beat budget >0 → REQ (second byte of pair, no flag check); else load settle counter with `SETTLE_CYC` → SETTLE.
- SETTLE: count down to 0 → WAIT.
- DONE: pulse `done`, clear `busy` → IDLE. ERR: set `error`, clear `busy` → IDLE; `remaining` holds residual.
- `tube_reset` in any non-IDLE state: `drq`=0, → IDLE next cycle, `busy`=0, no `done`, `error` unchanged, `remaining` holds.
- `start` when not IDLE: ignored.
- `remaining` never wraps below 0.

## Timing
- Reset values: `drq`=0, `busy`=0, `done`=0, `error`=0, `remaining`=0, state IDLE, synchronisers 0.
- Synchroniser latency 2 cycles; flag-to-`drq` latency = 2 (sync) + 1 (WAIT) + 1 (registered `drq`) = 4 cycles.
- `start`→`busy` high next cycle; `count`=0 → `done` 2 cycles after `start`.
- `drq` falls on the cycle after `dack_b` is seen low; beat completes on `dack_b` rising.
- Two-byte pair: second `drq` 1 cycle after first `dack_b` release.
- `done` occurs 1 cycle after the final `dack_b` release.

## Structure
- Package `tube_pkg`: state enum, `DIR_H2P`=0 / `DIR_P2H`=1 constants.
- Sub-module `tube_sync`: 2-flop synchroniser with async active-low reset, instantiated once per flag.

## Test plan
- `dir`=0, `count`=3, `two_byte`=0, `hp3_full_a` toggled per byte, `dack_b` low for 2 cycles → exactly 3 `drq` pulses, `remaining` 3→0, `done` once, `busy` low afterwards.
- `dir`=1, `count`=5, `two_byte`=1, `ph3_full_a`=0 → beats in pairs 2+2+1, `SETTLE_CYC` gap between pairs, `done` after the 5th.
- `dack_b` held high with `drq` asserted → `error`=1 after 255 cycles, `busy`=0, `remaining`=`count`; next `start` clears `error`.
- `tube_reset` pulsed in REQ with `count`=4 after 1 beat → `drq`=0, IDLE, `remaining`=3, no `done`.
- `count`=0 → `done` 2 cycles after `start`, no `drq`; `start` while busy → ignored, `remaining` unchanged.
- `rst_b` asserted mid-ACK → all outputs at reset values immediately, without waiting for a clock edge.
